// File: rtl/ins_encoder.sv
// RV32I field packer streaming encoded words to the instruction-memory loader.
// Define INS_ENCODER_RANGE_CHECK_EN to flag immediates outside the format range.
module ins_encoder #(
    parameter int ADDR_W    = 10,
    parameter int DEPTH     = 256,
    parameter int BASE_ADDR = 0
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [2:0]        fmt,
    input  logic [6:0]        opcode,
    input  logic [4:0]        rd,
    input  logic [2:0]        funct3,
    input  logic [4:0]        rs1,
    input  logic [4:0]        rs2,
    input  logic [6:0]        funct7,
    input  logic [31:0]       imm,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [31:0]       ins,
    output logic [ADDR_W-1:0] addr,
    output logic              done,
    output logic              err
);

    localparam int CW = $clog2(DEPTH + 1);
    localparam logic [CW-1:0] LAST = CW'(DEPTH - 1);
    localparam logic [ADDR_W-1:0] BASE = ADDR_W'(BASE_ADDR);
    localparam logic [31:0] NOP = 32'h0000_0013;

    typedef enum logic [1:0] {
        S_IDLE,
        S_LOAD,
        S_DONE
    } state_t;

    state_t        state;
    state_t        state_d;
    logic [CW-1:0] count;
    logic [31:0]   word;
    logic          bad;
    logic          rdy;
    logic          in_xfer;
    logic          out_xfer;
    logic          begin_load;

    assign in_xfer    = in_valid && rdy;
    assign out_xfer   = out_valid && out_ready;
    assign begin_load = start && (state != S_LOAD);
    assign in_ready   = rdy;
    assign done       = (state == S_DONE);

    always_comb begin
        state_d = state;
        rdy     = 1'b0;
        unique case (state)
            S_IDLE: begin
                if (start) state_d = S_LOAD;
            end
            S_LOAD: begin
                // Hold off the last-plus-one word so a session never overruns DEPTH.
                rdy = (!out_valid || out_ready) && !(out_valid && count == LAST);
                if (out_xfer && count == LAST) state_d = S_DONE;
            end
            S_DONE: begin
                if (start) state_d = S_LOAD;
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_comb begin
        word = NOP;
        bad  = 1'b0;
        unique case (fmt)
            3'd0: word = {funct7, rs2, rs1, funct3, rd, opcode};
            3'd1: word = {imm[11:0], rs1, funct3, rd, opcode};
            3'd2: word = {imm[11:5], rs2, rs1, funct3, imm[4:0], opcode};
            3'd3: word = {imm[12], imm[10:5], rs2, rs1, funct3,
                          imm[4:1], imm[11], opcode};
            3'd4: word = {imm[31:12], rd, opcode};
            3'd5: word = {imm[20], imm[10:1], imm[11], imm[19:12],
                          rd, opcode};
            default: begin
                word = NOP;
                bad  = 1'b1;
            end
        endcase
`ifdef INS_ENCODER_RANGE_CHECK_EN
        case (fmt)
            3'd1, 3'd2: bad = !((&imm[31:11]) || !(|imm[31:11]));
            3'd3: bad = !((&imm[31:12]) || !(|imm[31:12])) || imm[0];
            3'd4: bad = |imm[11:0];
            3'd5: bad = !((&imm[31:20]) || !(|imm[31:20])) || imm[0];
            default: ;
        endcase
`endif
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= S_IDLE;
            out_valid <= 1'b0;
            ins       <= 32'd0;
            addr      <= BASE;
            err       <= 1'b0;
            count     <= '0;
        end else begin
            state <= state_d;
            if (begin_load) begin
                count     <= '0;
                err       <= 1'b0;
                addr      <= BASE;
                out_valid <= 1'b0;
            end else begin
                if (out_xfer) begin
                    count <= count + CW'(1);
                    addr  <= addr + ADDR_W'(4);
                end
                if (in_xfer) begin
                    ins       <= word;
                    err       <= err | bad;
                    out_valid <= 1'b1;
                end else if (out_xfer) begin
                    out_valid <= 1'b0;
                end
            end
        end
    end

endmodule

// File: tb/tb_ins_encoder.sv
// Self-checking bench for ins_encoder: directed scenarios plus random sessions
// scored against a shift-and-mask encoder model.
module tb_ins_encoder;

    localparam int DEPTH = 4;
    localparam int ADDR_W = 10;
`ifdef INS_ENCODER_RANGE_CHECK_EN
    localparam bit RC = 1'b1;
`else
    localparam bit RC = 1'b0;
`endif

    logic              clk = 1'b0;
    logic              rst = 1'b1;
    logic              start = 1'b0;
    logic              in_valid = 1'b0;
    logic              in_ready;
    logic [2:0]        fmt = '0;
    logic [6:0]        opcode = '0;
    logic [4:0]        rd = '0;
    logic [2:0]        funct3 = '0;
    logic [4:0]        rs1 = '0;
    logic [4:0]        rs2 = '0;
    logic [6:0]        funct7 = '0;
    logic [31:0]       imm = '0;
    logic              out_valid;
    logic              out_ready = 1'b0;
    logic [31:0]       ins;
    logic [ADDR_W-1:0] addr;
    logic              done;
    logic              err;

    int total = 0;
    int bad = 0;

    ins_encoder #(.ADDR_W(ADDR_W), .DEPTH(DEPTH), .BASE_ADDR(0)) dut (
        .clk(clk), .rst(rst), .start(start),
        .in_valid(in_valid), .in_ready(in_ready),
        .fmt(fmt), .opcode(opcode), .rd(rd), .funct3(funct3),
        .rs1(rs1), .rs2(rs2), .funct7(funct7), .imm(imm),
        .out_valid(out_valid), .out_ready(out_ready),
        .ins(ins), .addr(addr), .done(done), .err(err)
    );

    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog total=%0d bad=%0d", total, bad);
        $fatal(1, "watchdog expired");
    end

    function automatic logic [31:0] m_encode(input logic [2:0] f,
            input logic [6:0] op, input logic [4:0] d, input logic [2:0] f3,
            input logic [4:0] s1, input logic [4:0] s2, input logic [6:0] f7,
            input logic [31:0] im);
        logic [31:0] o, dd, t3, a1, a2, t7;
        o = 32'(op); dd = 32'(d) << 7; t3 = 32'(f3) << 12;
        a1 = 32'(s1) << 15; a2 = 32'(s2) << 20; t7 = 32'(f7) << 25;
        case (f)
            3'd0: return t7 | a2 | a1 | t3 | dd | o;
            3'd1: return ((im & 32'hFFF) << 20) | a1 | t3 | dd | o;
            3'd2: return (((im >> 5) & 32'h7F) << 25) | a2 | a1 | t3
                         | ((im & 32'h1F) << 7) | o;
            3'd3: return (((im >> 12) & 1) << 31) | (((im >> 5) & 63) << 25)
                         | a2 | a1 | t3 | (((im >> 1) & 15) << 8)
                         | (((im >> 11) & 1) << 7) | o;
            3'd4: return (im & 32'hFFFF_F000) | dd | o;
            3'd5: return (((im >> 20) & 1) << 31) | (((im >> 1) & 1023) << 21)
                         | (((im >> 11) & 1) << 20) | (((im >> 12) & 255) << 12)
                         | dd | o;
            default: return 32'h0000_0013;
        endcase
    endfunction

    function automatic bit m_bad(input logic [2:0] f, input logic [31:0] im);
        int v;
        v = int'(im);
        if (f > 3'd5) return 1'b1;
        if (!RC) return 1'b0;
        case (f)
            3'd1, 3'd2: return (v < -2048) || (v > 2047);
            3'd3: return (v < -4096) || (v > 4095) || im[0];
            3'd4: return (im & 32'hFFF) != 0;
            3'd5: return (v < -(1 << 20)) || (v > (1 << 20) - 1) || im[0];
            default: return 1'b0;
        endcase
    endfunction

    task automatic pulse_start;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic put(input logic [2:0] f, input logic [6:0] op,
            input logic [4:0] d, input logic [2:0] f3, input logic [4:0] s1,
            input logic [4:0] s2, input logic [6:0] f7, input logic [31:0] im);
        int n;
        fmt = f; opcode = op; rd = d; funct3 = f3;
        rs1 = s1; rs2 = s2; funct7 = f7; imm = im;
        in_valid = 1'b1;
        #1;
        n = 0;
        while (!in_ready && n < 50) begin
            @(negedge clk);
            #1;
            n++;
        end
        total++;
        if (!in_ready) begin
            bad++;
            $display("FAIL put_ready in_ready=%b required 1", in_ready);
        end
        @(negedge clk);
        in_valid = 1'b0;
    endtask

    task automatic finish_session;
        int n;
        out_ready = 1'b1;
        fmt = 3'd1; opcode = 7'h13; rd = 5'd0; funct3 = 3'd0;
        rs1 = 5'd0; imm = 32'd0;
        in_valid = 1'b1;
        n = 0;
        while (!done && n < 100) begin
            @(negedge clk);
            n++;
        end
        in_valid = 1'b0;
        total++;
        if (!done) begin
            bad++;
            $display("FAIL drain_done done=%b required 1", done);
        end
    endtask

    task automatic test_reset;
        repeat (2) @(negedge clk);
        total += 4;
        if (out_valid !== 1'b0) begin bad++; $display("FAIL rst_valid got=%b exp=0", out_valid); end
        if (ins !== 32'd0) begin bad++; $display("FAIL rst_ins got=%h exp=0", ins); end
        if (addr !== '0) begin bad++; $display("FAIL rst_addr got=%h exp=0", addr); end
        if ({in_ready, done, err} !== 3'b000) begin
            bad++; $display("FAIL rst_flags got=%b exp=000", {in_ready, done, err});
        end
        rst = 1'b0;
        @(negedge clk);
        pulse_start;
        out_ready = 1'b0;
        put(3'd0, 7'h33, 5'd3, 3'd0, 5'd1, 5'd2, 7'd0, 32'd0);
        total++;
        if (out_valid !== 1'b1) begin bad++; $display("FAIL mid_valid got=%b exp=1", out_valid); end
        rst = 1'b1;
        #1;
        total += 2;
        if (out_valid !== 1'b0 || addr !== '0) begin
            bad++; $display("FAIL mid_rst valid=%b addr=%h exp 0/0", out_valid, addr);
        end
        if ({in_ready, done} !== 2'b00) begin
            bad++; $display("FAIL mid_rst_flags got=%b exp=00", {in_ready, done});
        end
        @(negedge clk);
        rst = 1'b0;
        in_valid = 1'b1;
        @(negedge clk);
        #1;
        total++;
        if (out_valid !== 1'b0 || in_ready !== 1'b0) begin
            bad++; $display("FAIL idle_hold valid=%b rdy=%b exp 0/0", out_valid, in_ready);
        end
        in_valid = 1'b0;
    endtask

    task automatic test_r_fmt;
        out_ready = 1'b1;
        pulse_start;
        put(3'd0, 7'h33, 5'd3, 3'd0, 5'd1, 5'd2, 7'd0, 32'd0);
        total++;
        if (!out_valid || ins !== 32'h002081B3 || addr !== 10'h000) begin
            bad++; $display("FAIL r_fmt v=%b ins=%h addr=%h exp 1/002081b3/000",
                            out_valid, ins, addr);
        end
    endtask

    task automatic test_back_to_back;
        put(3'd1, 7'h13, 5'd1, 3'd0, 5'd0, 5'd0, 7'd0, 32'd5);
        total++;
        if (!out_valid || ins !== 32'h00500093 || addr !== 10'h004) begin
            bad++; $display("FAIL b2b_i ins=%h addr=%h exp 00500093/004", ins, addr);
        end
        put(3'd2, 7'h23, 5'd0, 3'd2, 5'd1, 5'd2, 7'd0, 32'd8);
        total++;
        if (!out_valid || ins !== 32'h0020A423 || addr !== 10'h008) begin
            bad++; $display("FAIL b2b_s ins=%h addr=%h exp 0020a423/008", ins, addr);
        end
    endtask

    task automatic test_stall;
        put(3'd3, 7'h63, 5'd0, 3'd0, 5'd1, 5'd2, 7'd0, 32'hFFFF_FFFC);
        out_ready = 1'b0;
        repeat (3) begin
            #1;
            total++;
            if (!out_valid || ins !== 32'hFE208EE3 || addr !== 10'h00C || in_ready) begin
                bad++; $display("FAIL stall v=%b ins=%h addr=%h rdy=%b exp 1/fe208ee3/00c/0",
                                out_valid, ins, addr, in_ready);
            end
            @(negedge clk);
        end
        out_ready = 1'b1;
        @(negedge clk);
        #1;
        total++;
        if ({done, out_valid, in_ready} !== 3'b100) begin
            bad++; $display("FAIL depth_done got=%b exp=100", {done, out_valid, in_ready});
        end
    endtask

    task automatic test_illegal;
        pulse_start;
        out_ready = 1'b1;
        put(3'd7, 7'($urandom), 5'($urandom), 3'($urandom), 5'($urandom),
            5'($urandom), 7'($urandom), $urandom);
        total++;
        if (ins !== 32'h00000013 || err !== 1'b1 || addr !== 10'h000) begin
            bad++; $display("FAIL illegal ins=%h err=%b addr=%h exp 00000013/1/000",
                            ins, err, addr);
        end
        put(3'd1, 7'h13, 5'd1, 3'd0, 5'd0, 5'd0, 7'd0, 32'd5);
        total++;
        if (ins !== 32'h00500093 || err !== 1'b1 || addr !== 10'h004) begin
            bad++; $display("FAIL sticky ins=%h err=%b addr=%h exp 00500093/1/004",
                            ins, err, addr);
        end
        finish_session;
        total++;
        if (err !== 1'b1) begin bad++; $display("FAIL err_done got=%b exp=1", err); end
        pulse_start;
        #1;
        total++;
        if ({err, done, in_ready} !== 3'b001) begin
            bad++; $display("FAIL restart got=%b exp=001", {err, done, in_ready});
        end
        put(3'd1, 7'h13, 5'd1, 3'd0, 5'd0, 5'd0, 7'd0, 32'd2048);
        total++;
        if (err !== RC || ins !== 32'h80000093) begin
            bad++; $display("FAIL range err=%b ins=%h exp %b/80000093", err, ins, RC);
        end
        finish_session;
    endtask

    task automatic test_depth;
        logic [31:0] w;
        pulse_start;
        out_ready = 1'b1;
        for (int i = 0; i < DEPTH; i++) begin
            put(3'd4, 7'h37, 5'(i + 1), 3'd0, 5'd0, 5'd0, 7'd0, 32'(i) << 12);
            w = m_encode(3'd4, 7'h37, 5'(i + 1), 3'd0, 5'd0, 5'd0, 7'd0, 32'(i) << 12);
            total++;
            if (ins !== w || addr !== ADDR_W'(4 * i)) begin
                bad++; $display("FAIL depth_word%0d ins=%h addr=%h exp %h/%h",
                                i, ins, addr, w, ADDR_W'(4 * i));
            end
        end
        @(negedge clk);
        total++;
        if (done !== 1'b1 || in_ready !== 1'b0) begin
            bad++; $display("FAIL depth_end done=%b rdy=%b exp 1/0", done, in_ready);
        end
        pulse_start;
        put(3'd0, 7'h33, 5'd3, 3'd0, 5'd1, 5'd2, 7'd0, 32'd0);
        total++;
        if (addr !== '0 || ins !== 32'h002081B3) begin
            bad++; $display("FAIL depth_restart addr=%h ins=%h exp 000/002081b3", addr, ins);
        end
        finish_session;
    endtask

    task automatic test_random;
        logic [31:0] q[$];
        logic [ADDR_W-1:0] e_addr;
        int cnt, n;
        bit e_err, e_done, e_rdy, xo, xi;
        for (int s = 0; s < 20; s++) begin
            pulse_start;
            q.delete();
            cnt = 0; e_addr = '0; e_err = 0; e_done = 0; n = 0;
            while (n < 300) begin
                out_ready = ($urandom_range(0, 3) != 0);
                in_valid = $urandom_range(0, 1);
                fmt = 3'($urandom_range(0, 7));
                opcode = 7'($urandom); rd = 5'($urandom); funct3 = 3'($urandom);
                rs1 = 5'($urandom); rs2 = 5'($urandom); funct7 = 7'($urandom);
                if ($urandom_range(0, 3) == 0) imm = $urandom;
                else imm = 32'(int'($urandom_range(0, 8191)) - 4096);
                #1;
                e_rdy = !e_done && (q.size() == 0 || out_ready)
                        && !(q.size() != 0 && cnt == DEPTH - 1);
                total += 4;
                if (out_valid !== (q.size() != 0)) begin
                    bad++; $display("FAIL rnd_valid got=%b exp=%b", out_valid, q.size() != 0);
                end else if (q.size() != 0 && (ins !== q[0] || addr !== e_addr)) begin
                    bad++; $display("FAIL rnd_word ins=%h addr=%h exp %h/%h",
                                    ins, addr, q[0], e_addr);
                end
                if (err !== e_err) begin bad++; $display("FAIL rnd_err got=%b exp=%b", err, e_err); end
                if (done !== e_done) begin bad++; $display("FAIL rnd_done got=%b exp=%b", done, e_done); end
                if (in_ready !== e_rdy) begin
                    bad++; $display("FAIL rnd_ready got=%b exp=%b", in_ready, e_rdy);
                end
                if (e_done) break;
                xo = (q.size() != 0) && out_ready;
                xi = in_valid && e_rdy;
                if (xo) begin
                    void'(q.pop_front());
                    cnt++;
                    e_addr = e_addr + ADDR_W'(4);
                    if (cnt == DEPTH) e_done = 1;
                end
                if (xi) begin
                    q.push_back(m_encode(fmt, opcode, rd, funct3, rs1, rs2, funct7, imm));
                    e_err = e_err | m_bad(fmt, imm);
                end
                @(negedge clk);
                n++;
            end
            in_valid = 1'b0;
            total++;
            if (!e_done) begin bad++; $display("FAIL rnd_session%0d timeout", s); end
        end
    endtask

    initial begin
        test_reset;
        test_r_fmt;
        test_back_to_back;
        test_stall;
        test_illegal;
        test_depth;
        test_random;
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
